// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO: any depth, occupancy count, almost-full/empty thresholds, sticky errors, flush.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module sync_fifo_flex #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter int CNT_W         = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clr_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  full_o,
   output logic                  almost_full_o,
   output logic                  empty_o,
   output logic                  almost_empty_o,
   output logic [CNT_W-1:0]      count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_THRESH);
   localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AEMPTY_THRESH);

   generate
      if (DEPTH < 2) begin : g_bad_depth
         $error("sync_fifo_flex: DEPTH must be >= 2");
      end
      if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
         $error("sync_fifo_flex: AFULL_THRESH must be in 1..DEPTH");
      end
      if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
         $error("sync_fifo_flex: AEMPTY_THRESH must be in 0..DEPTH-1");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  ovf_q;
   logic                  udf_q;
   logic                  rd_acc;
   logic                  wr_acc;

   // Explicit wrap so non-power-of-two depths never index past the last entry.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign empty_o        = (count == '0);
   assign full_o         = (count == CNT_FULL);
   assign almost_full_o  = (count >= CNT_AF);
   assign almost_empty_o = (count <= CNT_AE);
   assign count_o        = count;
   assign overflow_o     = ovf_q;
   assign underflow_o    = udf_q;

   // A full FIFO still takes a write when the same edge pops a word.
   assign rd_acc = rd_en_i && !empty_o && !clr_i;
   assign wr_acc = wr_en_i && (!full_o || rd_acc) && !clr_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else if (clr_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (rd_acc) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (wr_acc && !rd_acc) begin
            count <= count + 1'b1;
         end else if (rd_acc && !wr_acc) begin
            count <= count - 1'b1;
         end
         if (wr_en_i && !wr_acc) begin
            ovf_q <= 1'b1;
         end
         if (rd_en_i && empty_o) begin
            udf_q <= 1'b1;
         end
      end
   end

   // Storage carries no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk_i) begin
      if (wr_acc) begin
         mem[wr_ptr] <= din_i;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign dout_o = mem[rd_ptr];
`else
   logic [DATA_WIDTH-1:0] dout_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         dout_q <= '0;
      end else if (clr_i) begin
         dout_q <= '0;
      end else if (rd_acc) begin
         dout_q <= mem[rd_ptr];
      end
   end

   assign dout_o = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex (DEPTH=8, AFULL=6, AEMPTY=2); table vectors plus corner sequences.
module tb_sync_fifo_flex;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk_i;
   logic          rstn_i;
   logic          clr_i;
   logic          wr_en_i;
   logic [DW-1:0] din_i;
   logic          rd_en_i;
   logic [DW-1:0] dout_o;
   logic          full_o;
   logic          almost_full_o;
   logic          empty_o;
   logic          almost_empty_o;
   logic [CW-1:0] count_o;
   logic          overflow_o;
   logic          underflow_o;

   int n_vec = 0;
   int n_err = 0;

   sync_fifo_flex #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AF),
      .AEMPTY_THRESH(AE)
   ) dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .clr_i         (clr_i),
      .wr_en_i       (wr_en_i),
      .din_i         (din_i),
      .rd_en_i       (rd_en_i),
      .dout_o        (dout_o),
      .full_o        (full_o),
      .almost_full_o (almost_full_o),
      .empty_o       (empty_o),
      .almost_empty_o(almost_empty_o),
      .count_o       (count_o),
      .overflow_o    (overflow_o),
      .underflow_o   (underflow_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          clr;
      logic          wr;
      logic [DW-1:0] din;
      logic          rd;
      int            cnt;
      logic [DW-1:0] dout;
      logic          ovf;
      logic          udf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic clr, input logic wr, input logic [DW-1:0] din, input logic rd,
                      input int cnt, input logic [DW-1:0] dout, input logic ovf, input logic udf);
      vec_t v;
      v.clr = clr; v.wr = wr; v.din = din; v.rd = rd;
      v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.udf = udf;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h at %0t", name, idx, act, exp, $time);
      end
   endtask

   task automatic check_status(input string tag, input int idx, input int cnt, input logic ovf, input logic udf);
      check({tag, ".count"}, idx, 32'(count_o), 32'(cnt));
      check({tag, ".empty"}, idx, 32'(empty_o), 32'(cnt == 0));
      check({tag, ".full"}, idx, 32'(full_o), 32'(cnt == DEPTH));
      check({tag, ".afull"}, idx, 32'(almost_full_o), 32'(cnt >= AF));
      check({tag, ".aempty"}, idx, 32'(almost_empty_o), 32'(cnt <= AE));
      check({tag, ".ovf"}, idx, 32'(overflow_o), 32'(ovf));
      check({tag, ".udf"}, idx, 32'(underflow_o), 32'(udf));
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      clr_i   = 1'b0;
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] d;

      rstn_i  = 1'b0;
      clr_i   = 1'b0;
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      din_i   = '0;

      // Full, overflow, full read+write, drain, underflow cases, flush.
      for (int k = 1; k <= 8; k++) add(0, 1, 8'(17 * k), 0, k, 8'h00, 0, 0);
      add(0, 1, 8'hFF, 0, 8, 8'h00, 1, 0);
      add(0, 1, 8'hAB, 1, 8, 8'h11, 1, 0);
      for (int j = 1; j <= 7; j++) add(0, 0, 8'h00, 1, 8 - j, 8'(17 * (j + 1)), 1, 0);
      add(0, 0, 8'h00, 1, 0, 8'hAB, 1, 0);
      add(0, 0, 8'h00, 1, 0, 8'hAB, 1, 1);
      add(0, 1, 8'h5A, 1, 1, 8'hAB, 1, 1);
      add(0, 0, 8'h00, 1, 0, 8'h5A, 1, 1);
      add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);

      #12;
      check_status("reset", 0, 0, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check("reset.dout", 0, 32'(dout_o), 32'h0);
`endif
      #1 rstn_i = 1'b1;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         clr_i   = vecs[i].clr;
         wr_en_i = vecs[i].wr;
         din_i   = vecs[i].din;
         rd_en_i = vecs[i].rd;
         step();
         check_status("vec", i, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
`ifndef SYNC_FIFO_FWFT_EN
         check("vec.dout", i, 32'(dout_o), 32'(vecs[i].dout));
`endif
      end

      // Pointer wrap: 20 write/read pairs walk the pointers around twice.
      for (int i = 0; i < 20; i++) begin
         d = 8'(8'h60 + i);
         wr_en_i = 1'b1;
         din_i   = d;
         step();
         check("wrap.cnt1", i, 32'(count_o), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
         check("wrap.fwft_dout", i, 32'(dout_o), 32'(d));
`endif
         rd_en_i = 1'b1;
         step();
         check("wrap.cnt0", i, 32'(count_o), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
         check("wrap.dout", i, 32'(dout_o), 32'(d));
`endif
      end

      rd_en_i = 1'b1;
      step();
      check("pre_clr.udf", 0, 32'(underflow_o), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         wr_en_i = 1'b1;
         din_i   = 8'(i);
         step();
      end
      check("pre_clr.count", 0, 32'(count_o), 32'd3);
      clr_i   = 1'b1;
      wr_en_i = 1'b1;
      din_i   = 8'hEE;
      step();
      check_status("clr", 0, 0, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check("clr.dout", 0, 32'(dout_o), 32'h0);
`endif
      wr_en_i = 1'b1;
      din_i   = 8'h77;
      step();
`ifdef SYNC_FIFO_FWFT_EN
      check("post_clr.dout", 0, 32'(dout_o), 32'h77);
`endif
      rd_en_i = 1'b1;
      step();
`ifndef SYNC_FIFO_FWFT_EN
      check("post_clr.dout", 0, 32'(dout_o), 32'h77);
`endif
      check("post_clr.empty", 0, 32'(empty_o), 32'd1);

`ifdef SYNC_FIFO_FWFT_EN
      wr_en_i = 1'b1;
      din_i   = 8'h3C;
      step();
      check("fwft.dout", 0, 32'(dout_o), 32'h3C);
      check("fwft.empty", 0, 32'(empty_o), 32'd0);
      check("fwft.count", 0, 32'(count_o), 32'd1);
      rd_en_i = 1'b1;
      step();
      check("fwft.pop_empty", 0, 32'(empty_o), 32'd1);
`endif

      // Asynchronous reset between clock edges with a full, overflowed FIFO.
      for (int i = 0; i < 9; i++) begin
         wr_en_i = 1'b1;
         din_i   = 8'(8'hA0 + i);
         step();
      end
      rd_en_i = 1'b1;
      step();
      check("arst_pre.ovf", 0, 32'(overflow_o), 32'd1);
      check("arst_pre.count", 0, 32'(count_o), 32'd7);
      #3 rstn_i = 1'b0;
      #1;
      check_status("arst", 0, 0, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check("arst.dout", 0, 32'(dout_o), 32'h0);
`endif
      #2 rstn_i = 1'b1;
      step();
      check_status("arst_post", 0, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
